i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum clk cycles from m_start to m_done before the transaction is flagged as an error.
REQ-002 clk  input  1  system clock; all logic SHALL be rising-edge triggered.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  upstream command valid.
REQ-005 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-006 cmd_rw  input  1  1 = read, 0 = write.
REQ-007 cmd_slave  input  7  target slave address.
REQ-008 cmd_reg  input  7  target register address.
REQ-009 cmd_wdata  input  8  write payload.
REQ-010 rsp_valid  output  1  response valid.
REQ-011 rsp_ready  input  1  downstream accepts the response.
REQ-012 rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  1 = timeout.
REQ-014 m_start  output  1  start pulse to the I2C master.
REQ-015 m_read_write, m_slave_addr[6:0], m_reg_addr[6:0], m_data_in[7:0]  outputs  transaction fields to the master.
REQ-016 m_busy  input  1; m_done  input  1 (single-cycle pulse); m_data_out  input  8  master status and read data.
REQ-017 err_count  output  8  saturating count of timed-out transactions.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT_DONE and RESP.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, latch cmd_rw/slave/reg/wdata into holding registers and go to ISSUE next cycle.
REQ-020 cmd_ready SHALL be 0 in every state except IDLE; only one command is outstanding at a time.
REQ-021 ISSUE: while m_busy=1, hold without starting; once m_busy=0, assert m_start for exactly one cycle, clear the watchdog, and go to WAIT_DONE.
REQ-022 m_read_write, m_slave_addr, m_reg_addr and m_data_in SHALL be driven from the holding registers and stay stable from ISSUE entry until WAIT_DONE exit.
REQ-023 WAIT_DONE: the watchdog SHALL increment every cycle.
REQ-024 On m_done=1: rsp_rdata = m_data_out if read, else 0; rsp_err=0; go to RESP.
REQ-025 If the watchdog reaches TIMEOUT_CYCLES-1 without m_done: rsp_rdata=0, rsp_err=1, err_count increments (saturating at 255), and the FSM goes to RESP.
REQ-026 If m_done and timeout coincide in the same cycle, m_done SHALL win (no error).
REQ-027 RESP: rsp_valid=1 with rsp_rdata/rsp_err held stable until rsp_ready=1; on that cycle return to IDLE.
REQ-028 Command-to-m_start latency SHALL be 2 cycles when m_busy=0.
REQ-029 The rsp_valid-to-cmd_ready turnaround SHALL be 1 cycle after the handshake.
REQ-030 m_done asserted outside WAIT_DONE SHALL be ignored.

Reset
REQ-031 While rst_n=0: state=IDLE; cmd_ready=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; m_start=0; m_* fields=0; watchdog=0; err_count=0.
REQ-032 cmd_ready SHALL rise in the first clk edge after reset release.
REQ-033 Reset asserted mid-transaction SHALL abort it without producing a response.

Structure
REQ-034 A shared package i2c_pkg SHALL hold the FSM state encoding and the default TIMEOUT_CYCLES constant.
REQ-035 The watchdog counter SHALL be a sub-module i2c_watchdog (clear, enable, expired output), with width derived from TIMEOUT_CYCLES via clog2.

Verification
REQ-036 Write cmd (rw=0, slave=0x48, reg=0x01, wdata=0xA5) with a master model giving m_done after 40 cycles -> m_start is one cycle wide 2 cycles after accept; fields stable; rsp rdata=0x00, err=0.
REQ-037 Read cmd (rw=1, slave=0x68, reg=0x75) with model returning m_data_out=0x71 -> rsp_rdata=0x71, err=0.
REQ-038 Master never returns m_done, TIMEOUT_CYCLES=16 -> rsp_err=1 at cycle 16 after m_start, rdata=0, err_count=1; 300 such timeouts -> err_count=255.
REQ-039 rsp_ready held low 10 cycles -> rsp_valid and data stable, cmd_ready=0 throughout; cmd_ready=1 one cycle after the handshake.
REQ-040 m_busy=1 on ISSUE entry for 5 cycles -> no m_start until m_busy falls; m_done coinciding with timeout -> err=0.
REQ-041 rst_n pulsed low in WAIT_DONE -> all outputs return to reset values and no rsp_valid is produced.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C command sequencer and its watchdog.
package i2c_pkg;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4096;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StIssue    = 2'd1,
      StWaitDone = 2'd2,
      StResp     = 2'd3
   } seq_state_e;

   // Counter width able to hold 0 .. n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2c_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CYCLES-1.
module i2c_watchdog
   import i2c_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned  W    = cnt_width(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   assign expired = (count == LAST);

   // Stops at LAST so a stalled owner can never wrap back below the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Single-outstanding command sequencer: accepts a register read/write command,
// launches it on the I2C master, and returns the result or a timeout error.
module i2c_cmd_sequencer
   import i2c_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_slave,
   input  logic [6:0] cmd_reg,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       m_start,
   output logic       m_read_write,
   output logic [6:0] m_slave_addr,
   output logic [6:0] m_reg_addr,
   output logic [7:0] m_data_in,
   input  logic       m_busy,
   input  logic       m_done,
   input  logic [7:0] m_data_out,
   output logic [7:0] err_count
);

   seq_state_e state;

   logic       hold_rw;
   logic [6:0] hold_slave;
   logic [6:0] hold_reg;
   logic [7:0] hold_wdata;

   logic wd_clear;
   logic wd_enable;
   logic wd_expired;

   assign wd_clear  = (state == StIssue) && !m_busy;
   assign wd_enable = (state == StWaitDone);

   i2c_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Holding registers only change on accept, so the master sees stable fields.
   assign m_read_write = hold_rw;
   assign m_slave_addr = hold_slave;
   assign m_reg_addr   = hold_reg;
   assign m_data_in    = hold_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 8'h00;
         rsp_err    <= 1'b0;
         m_start    <= 1'b0;
         hold_rw    <= 1'b0;
         hold_slave <= 7'h00;
         hold_reg   <= 7'h00;
         hold_wdata <= 8'h00;
         err_count  <= 8'h00;
      end else begin
         m_start <= 1'b0;
         unique case (state)
            StIdle: begin
               if (cmd_valid && cmd_ready) begin
                  hold_rw    <= cmd_rw;
                  hold_slave <= cmd_slave;
                  hold_reg   <= cmd_reg;
                  hold_wdata <= cmd_wdata;
                  cmd_ready  <= 1'b0;
                  state      <= StIssue;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            StIssue: begin
               if (!m_busy) begin
                  m_start <= 1'b1;
                  state   <= StWaitDone;
               end
            end
            StWaitDone: begin
               // A completion in the expiry cycle still counts as success.
               if (m_done) begin
                  rsp_rdata <= hold_rw ? m_data_out : 8'h00;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
               end else if (wd_expired) begin
                  rsp_rdata <= 8'h00;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
                  state <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 8'h00;
                  rsp_err   <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench: dut_to (TIMEOUT_CYCLES=16) covers timeouts, dut_def (default)
// covers long transactions; sel picks which one the shared stimulus addresses.
module tb_i2c_cmd_sequencer;

   logic       clk;
   logic       rst_n;
   logic       sel;
   logic       cmd_valid;
   logic       cmd_rw;
   logic [6:0] cmd_slave;
   logic [6:0] cmd_reg;
   logic [7:0] cmd_wdata;
   logic       rsp_ready;
   logic       m_busy;
   logic       m_done;
   logic [7:0] m_data_out;

   logic       a_cmd_ready, b_cmd_ready;
   logic       a_rsp_valid, b_rsp_valid;
   logic [7:0] a_rsp_rdata, b_rsp_rdata;
   logic       a_rsp_err, b_rsp_err;
   logic       a_m_start, b_m_start;
   logic       a_m_rw, b_m_rw;
   logic [6:0] a_m_slave, b_m_slave;
   logic [6:0] a_m_reg, b_m_reg;
   logic [7:0] a_m_data, b_m_data;
   logic [7:0] a_err_count, b_err_count;

   logic       cmd_ready, rsp_valid, rsp_err, m_start, m_read_write;
   logic [7:0] rsp_rdata, m_data_in, err_count;
   logic [6:0] m_slave_addr, m_reg_addr;

   int n_chk = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   i2c_cmd_sequencer #(
      .TIMEOUT_CYCLES(16)
   ) dut_to (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid && !sel),
      .cmd_ready    (a_cmd_ready),
      .cmd_rw       (cmd_rw),
      .cmd_slave    (cmd_slave),
      .cmd_reg      (cmd_reg),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (a_rsp_valid),
      .rsp_ready    (rsp_ready && !sel),
      .rsp_rdata    (a_rsp_rdata),
      .rsp_err      (a_rsp_err),
      .m_start      (a_m_start),
      .m_read_write (a_m_rw),
      .m_slave_addr (a_m_slave),
      .m_reg_addr   (a_m_reg),
      .m_data_in    (a_m_data),
      .m_busy       (m_busy),
      .m_done       (m_done && !sel),
      .m_data_out   (m_data_out),
      .err_count    (a_err_count)
   );

   i2c_cmd_sequencer dut_def (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid && sel),
      .cmd_ready    (b_cmd_ready),
      .cmd_rw       (cmd_rw),
      .cmd_slave    (cmd_slave),
      .cmd_reg      (cmd_reg),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (b_rsp_valid),
      .rsp_ready    (rsp_ready && sel),
      .rsp_rdata    (b_rsp_rdata),
      .rsp_err      (b_rsp_err),
      .m_start      (b_m_start),
      .m_read_write (b_m_rw),
      .m_slave_addr (b_m_slave),
      .m_reg_addr   (b_m_reg),
      .m_data_in    (b_m_data),
      .m_busy       (m_busy),
      .m_done       (m_done && sel),
      .m_data_out   (m_data_out),
      .err_count    (b_err_count)
   );

   assign cmd_ready    = sel ? b_cmd_ready : a_cmd_ready;
   assign rsp_valid    = sel ? b_rsp_valid : a_rsp_valid;
   assign rsp_rdata    = sel ? b_rsp_rdata : a_rsp_rdata;
   assign rsp_err      = sel ? b_rsp_err   : a_rsp_err;
   assign m_start      = sel ? b_m_start   : a_m_start;
   assign m_read_write = sel ? b_m_rw      : a_m_rw;
   assign m_slave_addr = sel ? b_m_slave   : a_m_slave;
   assign m_reg_addr   = sel ? b_m_reg     : a_m_reg;
   assign m_data_in    = sel ? b_m_data    : a_m_data;
   assign err_count    = sel ? b_err_count : a_err_count;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents one command at a negedge; returns at the following negedge (ISSUE).
   task automatic accept(input logic rw, input logic [6:0] slave, input logic [6:0] rg,
                         input logic [7:0] wd);
      check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_slave = slave;
      cmd_reg   = rg;
      cmd_wdata = wd;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(output int waited);
      waited = 0;
      while (m_start !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("m_start_seen", 32'(m_start), 32'd1);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
      check("cmd_ready_turnaround", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int         w;
      logic       ok;
      logic [7:0] exp_ec;

      rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_slave = 7'h00;
      cmd_reg = 7'h00; cmd_wdata = 8'h00; rsp_ready = 1'b0; m_busy = 1'b0;
      m_done = 1'b0; m_data_out = 8'h00; exp_ec = 8'h00;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_m_start", 32'(m_start), 32'd0);
      check("rst_m_slave", 32'(m_slave_addr), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

      // Write, master completes 40 cycles after m_start.
      sel = 1'b1;
      #1;
      accept(1'b0, 7'h48, 7'h01, 8'hA5);
      check("wr_issue_no_start", 32'(m_start), 32'd0);
      check("wr_issue_cmd_ready", 32'(cmd_ready), 32'd0);
      check("wr_issue_slave", 32'(m_slave_addr), 32'h48);
      wait_start(w);
      check("wr_start_latency", 32'(w + 1), 32'd2);
      check("wr_m_rw", 32'(m_read_write), 32'd0);
      check("wr_m_reg", 32'(m_reg_addr), 32'h01);
      check("wr_m_data", 32'(m_data_in), 32'hA5);
      ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (m_start !== 1'b0 || rsp_valid !== 1'b0 || m_slave_addr !== 7'h48 ||
             m_reg_addr !== 7'h01 || m_data_in !== 8'hA5 || m_read_write !== 1'b0) ok = 1'b0;
         if (k == 40) begin
            m_done = 1'b1;
            m_data_out = 8'hEE;
         end
      end
      @(negedge clk);
      m_done = 1'b0;
      check("wr_wait_stable", 32'(ok), 32'd1);
      check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("wr_rsp_rdata", 32'(rsp_rdata), 32'h00);
      check("wr_rsp_err", 32'(rsp_err), 32'd0);
      handshake();

      // Read returning 0x71.
      accept(1'b1, 7'h68, 7'h75, 8'h00);
      wait_start(w);
      check("rd_m_rw", 32'(m_read_write), 32'd1);
      check("rd_m_slave", 32'(m_slave_addr), 32'h68);
      check("rd_m_reg", 32'(m_reg_addr), 32'h75);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 5) begin
            m_done = 1'b1;
            m_data_out = 8'h71;
         end
      end
      @(negedge clk);
      m_done = 1'b0;
      check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rd_rsp_rdata", 32'(rsp_rdata), 32'h71);
      check("rd_rsp_err", 32'(rsp_err), 32'd0);
      handshake();

      // Response back-pressure for 10 cycles; stray m_done must be ignored.
      accept(1'b1, 7'h50, 7'h10, 8'h00);
      wait_start(w);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 3) begin
            m_done = 1'b1;
            m_data_out = 8'h3C;
         end
      end
      @(negedge clk);
      m_done = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0 ||
             cmd_ready !== 1'b0) ok = 1'b0;
         if (k == 4) begin
            m_done = 1'b1;
            m_data_out = 8'hFF;
         end
         if (k == 5) m_done = 1'b0;
         @(negedge clk);
      end
      check("resp_hold_stable", 32'(ok), 32'd1);
      check("resp_hold_rdata", 32'(rsp_rdata), 32'h3C);
      handshake();
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      @(negedge clk);
      check("idle_m_done_ignored", 32'(rsp_valid), 32'd0);
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // Timeout with TIMEOUT_CYCLES=16: response 16 cycles after m_start.
      sel = 1'b0;
      #1;
      accept(1'b0, 7'h2A, 7'h03, 8'h11);
      wait_start(w);
      ok = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) ok = 1'b0;
      end
      check("to_no_early_rsp", 32'(ok), 32'd1);
      @(negedge clk);
      exp_ec = 8'd1;
      check("to_rsp_valid", 32'(rsp_valid), 32'd1);
      check("to_rsp_err", 32'(rsp_err), 32'd1);
      check("to_rsp_rdata", 32'(rsp_rdata), 32'h00);
      check("to_err_count", 32'(err_count), 32'(exp_ec));
      handshake();

      // Busy master delays m_start; m_done on the expiry cycle wins.
      m_busy = 1'b1;
      accept(1'b1, 7'h1E, 7'h22, 8'h00);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (m_start !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      if (m_start !== 1'b0) ok = 1'b0;
      m_busy = 1'b0;
      check("busy_holds_start", 32'(ok), 32'd1);
      @(negedge clk);
      check("start_after_busy", 32'(m_start), 32'd1);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 15) begin
            m_done = 1'b1;
            m_data_out = 8'h5A;
         end
      end
      @(negedge clk);
      m_done = 1'b0;
      check("coincide_rsp_valid", 32'(rsp_valid), 32'd1);
      check("coincide_rsp_err", 32'(rsp_err), 32'd0);
      check("coincide_rsp_rdata", 32'(rsp_rdata), 32'h5A);
      check("coincide_err_count", 32'(err_count), 32'(exp_ec));
      handshake();

      // 299 more timeouts (300 in total) saturate the error counter.
      ok = 1'b1;
      for (int i = 0; i < 299; i++) begin
         accept(1'b0, 7'h10, 7'h00, 8'h00);
         wait_start(w);
         w = 0;
         while (rsp_valid !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
         end
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) ok = 1'b0;
         if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
         handshake();
      end
      check("sat_all_timed_out", 32'(ok), 32'd1);
      check("sat_err_count", 32'(err_count), 32'(exp_ec));

      // Reset in WAIT_DONE aborts without a response.
      sel = 1'b1;
      #1;
      accept(1'b0, 7'h33, 7'h44, 8'h55);
      wait_start(w);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("abort_rsp_err", 32'(rsp_err), 32'd0);
      check("abort_m_start", 32'(m_start), 32'd0);
      check("abort_m_rw", 32'(m_read_write), 32'd0);
      check("abort_m_slave", 32'(m_slave_addr), 32'd0);
      check("abort_m_reg", 32'(m_reg_addr), 32'd0);
      check("abort_m_data", 32'(m_data_in), 32'd0);
      sel = 1'b0;
      #1;
      check("abort_err_count_cleared", 32'(err_count), 32'd0);
      sel = 1'b1;
      @(negedge clk);
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      rst_n = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) ok = 1'b0;
         m_done = (k == 3);
      end
      m_done = 1'b0;
      check("abort_no_rsp", 32'(ok), 32'd1);
      check("abort_cmd_ready_back", 32'(cmd_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
